// File: rtl/steer_pkg.sv
// rtl/steer_pkg.sv - shared types and constants for the steering enable controller
//
// Purpose: state encoding, timer widths and default rider-weight thresholds
// used by steer_en_ctrl and steer_tmr.
// Ports: none (package).
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_t;

  localparam int TMR_W_FULL = 26;
  localparam int TMR_W_FAST = 15;

  localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
  localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h040;

  // Unsigned |a - b| without a sign bit.
  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/steer_tmr.sv
// rtl/steer_tmr.sv - saturating balance timer for the steering enable controller
//
// Purpose: 26-bit up-counter; tmr_full when the compared low bits are all 1
// (15 bits when FAST_SIM=1, 26 bits otherwise). clr wins over en.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   clr      in   clear counter to 0
//   en       in   count one step (ignored once full)
//   tmr_full out  terminal count reached
module steer_tmr
  import steer_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tmr_full
);

  localparam int CMP_W = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;

  logic [TMR_W_FULL-1:0] cnt_q;
  logic [TMR_W_FULL-1:0] cnt_d;

  assign tmr_full = &cnt_q[CMP_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tmr_full) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/steer_en_ctrl.sv
// rtl/steer_en_ctrl.sv - rider presence / balance decision and timed steering enable
//
// Purpose: from held left/right load-cell readings decide rider presence (with
// hysteresis) and balance, and enable steering once balance has been held for
// the timer period. Optional macro STEER_DIAG_EN adds a STEER-exit counter.
// Ports:
//   clk            in   50 MHz system clock
//   rst            in   asynchronous active-high reset
//   lft_ld[11:0]   in   left load cell reading, unsigned
//   rght_ld[11:0]  in   right load cell reading, unsigned
//   en_steer       out  steering enabled (registered)
//   rider_off      out  no rider present (registered)
//   steer_dropouts out  [7:0] saturating STEER exit count (STEER_DIAG_EN only)
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter bit          FAST_SIM      = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
`ifdef STEER_DIAG_EN
  output logic [7:0]  steer_dropouts,
`endif
  output logic        rider_off
);

  localparam logic [12:0] PRES_SET = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
  localparam logic [12:0] PRES_CLR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  logic [12:0]  sum;
  logic [11:0]  diff;
  logic         diff_small;
  logic         diff_big;

  steer_state_t state_q, state_d;
  logic         rider_pres_q, rider_pres_d;
  logic         en_steer_q, rider_off_q;
  logic         clr_tmr, cnt_en, tmr_full;

  assign sum        = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff       = abs_diff(lft_ld, rght_ld);
  assign diff_small = {1'b0, diff} < (sum >> 2);
  // 3/4 of sum built from two shifts; max 6142 still fits 13 bits.
  assign diff_big   = {1'b0, diff} > ((sum >> 1) + (sum >> 2));

  // Presence only changes outside the dead band [PRES_CLR, PRES_SET].
  always_comb begin
    rider_pres_d = rider_pres_q;
    if (sum > PRES_SET) begin
      rider_pres_d = 1'b1;
    end else if (sum < PRES_CLR) begin
      rider_pres_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_tmr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rider_pres_q) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      WAIT: begin
        if (!rider_pres_q) begin
          state_d = IDLE;
        end else if (!diff_small) begin
          clr_tmr = 1'b1;  // any imbalance restarts the hold period
        end else if (tmr_full) begin
          state_d = STEER;
        end else begin
          cnt_en = 1'b1;
        end
      end
      STEER: begin
        // Loss of presence is checked first so it beats diff_big.
        if (!rider_pres_q) begin
          state_d = IDLE;
        end else if (diff_big) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  steer_tmr #(
    .FAST_SIM (FAST_SIM)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_tmr),
    .en       (cnt_en),
    .tmr_full (tmr_full)
  );

  // Outputs decoded from next state so they move with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rider_pres_q <= 1'b0;
      en_steer_q   <= 1'b0;
      rider_off_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      rider_pres_q <= rider_pres_d;
      en_steer_q   <= (state_d == STEER);
      rider_off_q  <= (state_d == IDLE);
    end
  end

  assign en_steer  = en_steer_q;
  assign rider_off = rider_off_q;

`ifdef STEER_DIAG_EN
  logic [7:0] drops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drops_q <= 8'h00;
    end else if ((state_q == STEER) && (state_d != STEER) && (drops_q != 8'hFF)) begin
      drops_q <= drops_q + 8'h01;
    end
  end

  assign steer_dropouts = drops_q;
`endif

endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb/tb_steer_en_ctrl.sv - scoreboard bench for steer_en_ctrl with FAST_SIM=1
`timescale 1ns/1ps
module tb_steer_en_ctrl;

  localparam int HOLD_N = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;
`ifdef STEER_DIAG_EN
  logic [7:0]  steer_dropouts;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit en;
    bit off;
    int drops;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: presence flag, mode (0 idle, 1 waiting, 2 steering),
  // length of the current unbroken balanced run while waiting, exit count.
  bit m_pres;
  int m_mode;
  int m_run;
  int m_drops;

  steer_en_ctrl #(
    .FAST_SIM (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lft_ld         (lft_ld),
    .rght_ld        (rght_ld),
    .en_steer       (en_steer),
`ifdef STEER_DIAG_EN
    .steer_dropouts (steer_dropouts),
`endif
    .rider_off      (rider_off)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pres  = 1'b0;
    m_mode  = 0;
    m_run   = 0;
    m_drops = 0;
  endfunction

  // Advance the model by one clock for the given inputs and queue the
  // outputs expected after that clock edge.
  function automatic void model_step(input int l, input int r);
    int   sum, diff, nm;
    bit   bal, big;
    exp_t e;
    sum  = l + r;
    diff = (l > r) ? l - r : r - l;
    bal  = diff < (sum / 4);
    big  = diff > (sum / 2 + sum / 4);
    nm   = m_mode;
    if (m_mode == 0) begin
      if (m_pres) begin nm = 1; m_run = 0; end
    end else if (m_mode == 1) begin
      if (!m_pres) nm = 0;
      else if (!bal) m_run = 0;
      else begin
        m_run++;
        if (m_run == HOLD_N) nm = 2;
      end
    end else begin
      if (!m_pres) nm = 0;
      else if (big) begin nm = 1; m_run = 0; end
    end
    if (m_mode == 2 && nm != 2 && m_drops < 255) m_drops++;
    m_mode = nm;
    if (sum > 576) m_pres = 1'b1;
    else if (sum < 448) m_pres = 1'b0;
    e.en    = (nm == 2);
    e.off   = (nm == 0);
    e.drops = m_drops;
    exp_q.push_back(e);
  endfunction

  // Called at a negedge: drive inputs for the next edge, then wait one cycle.
  task automatic step(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
    model_step(int'(l), int'(r));
    @(negedge clk);
  endtask

  task automatic step_n(input logic [11:0] l, input logic [11:0] r, input int n);
    for (int i = 0; i < n; i++) step(l, r);
  endtask

  // Steps balanced loads until en_steer rises; returns the number of steps.
  task automatic run_to_steer(input logic [11:0] l, input logic [11:0] r, output int n);
    n = 0;
    do begin
      step(l, r);
      n++;
    end while (en_steer !== 1'b1 && n < 40000);
  endtask

  // Monitor: whenever an expectation is pending, compare it just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("en_steer", int'(en_steer), int'(mon_e.en));
      chk("rider_off", int'(rider_off), int'(mon_e.off));
`ifdef STEER_DIAG_EN
      chk("steer_dropouts", int'(steer_dropouts), mon_e.drops);
`endif
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [11:0] l, r;
    rst     = 1'b1;
    lft_ld  = 12'h000;
    rght_ld = 12'h000;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_en_steer", int'(en_steer), 0);
    chk("reset_rider_off", int'(rider_off), 1);

    // Empty platform stays idle.
    step_n(12'h000, 12'h000, 1000);

    // Full-scale equal loads: no wrap, diff 0 is balanced.
    step_n(12'hFFF, 12'hFFF, 20);
    step_n(12'h000, 12'h000, 5);

    // Random loads around the presence and balance boundaries.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 4))
        0: begin l = 12'(224 + $urandom_range(0, 100)); r = 12'(224 + $urandom_range(0, 100)); end
        1: begin l = 12'h150 + 12'($urandom_range(0, 40)); r = 12'h150 - 12'($urandom_range(0, 40)); end
        2: begin l = 12'($urandom_range(0, 4095)); r = 12'($urandom_range(0, 64)); end
        3: begin l = 12'($urandom_range(0, 4095)); r = 12'($urandom_range(0, 4095)); end
        default: begin l = 12'h000; r = 12'h000; end
      endcase
      step_n(l, r, $urandom_range(1, 20));
    end
    step_n(12'h000, 12'h000, 5);
    chk("idle_after_random", int'(rider_off), 1);

    // Balanced rider: presence after one edge, WAIT after two.
    step(12'h150, 12'h150);
    chk("pres_cycle1_still_off", int'(rider_off), 1);
    step(12'h150, 12'h150);
    chk("wait_cycle2_rider_on", int'(rider_off), 0);
    step_n(12'h150, 12'h150, 1000);

    // Imbalance in WAIT restarts the hold period from zero.
    step_n(12'h300, 12'h050, 100);
    run_to_steer(12'h150, 12'h150, n);
    chk("steer_latency_after_restore", n, HOLD_N);

    // Sum 500 is inside the hysteresis band: still steering.
    step_n(12'h0FA, 12'h0FA, 20);
    chk("hyst_500_stays_steer", int'(en_steer), 1);

    // Large imbalance drops back to WAIT.
    step(12'h3F0, 12'h010);
    chk("diff_big_en_low", int'(en_steer), 0);
    chk("diff_big_rider_on", int'(rider_off), 0);
`ifdef STEER_DIAG_EN
    chk("dropouts_one", int'(steer_dropouts), 1);
`endif

    run_to_steer(12'h150, 12'h150, n);
    chk("steer_latency_second", n, HOLD_N);

    // Asynchronous reset while steering, between clock edges.
    lft_ld  = 12'h150;
    rght_ld = 12'h150;
    model_step(12'h150, 12'h150);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_en_steer", int'(en_steer), 0);
    chk("async_rst_rider_off", int'(rider_off), 1);
`ifdef STEER_DIAG_EN
    chk("async_rst_dropouts", int'(steer_dropouts), 0);
`endif
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Recovery needs a fresh full hold period.
    step_n(12'h150, 12'h150, 2000);
    chk("recovery_not_steering", int'(en_steer), 0);
    chk("recovery_waiting", int'(rider_off), 0);

    // Sum 400 is below the clear threshold: back to idle.
    step_n(12'h0C8, 12'h0C8, 3);
    chk("sum400_rider_off", int'(rider_off), 1);

    // Sum 500 from idle does not reach the set threshold.
    step_n(12'h0FA, 12'h0FA, 10);
    chk("sum500_stays_idle", int'(rider_off), 1);

    step(12'h000, 12'h000);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
